// File: rtl/div_stall_ctrl.sv
// rtl/div_stall_ctrl.sv - iterative restoring divider with pipeline stall control for the hi/lo path
module div_stall_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stallreq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] part_quo;
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;

  logic             last_step;
  logic             dvs_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign dvs_zero  = (divisor == '0);

  // Operand magnitudes; DIVU passes operands through untouched, and -MIN wraps to MIN which is the correct magnitude unsigned.
  always_comb begin
    dvd_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor, keep on non-negative.
  always_comb begin
    shifted  = {part_rem, part_quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_mag};
    step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {part_quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and control outputs; stall drops in DONE so the pipeline captures the result that cycle.
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stallreq  = 1'b1;
          state_nxt = dvs_zero ? DONE : CALC;
        end
      end
      CALC: begin
        stallreq = 1'b1;
        busy     = 1'b1;
        if (cancel)         state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cpu_rst) stallreq = 1'b0;
  end

  // Datapath: operand capture, iteration, and result registration with signed fix-up on entry to DONE.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt         <= '0;
      part_rem    <= '0;
      part_quo    <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dvs_zero) begin
              quo         <= '0;
              rem         <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              part_rem <= '0;
              part_quo <= dvd_abs;
              dvs_mag  <= dvs_abs;
              neg_q    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r    <= signed_op && dividend[WIDTH-1];
              cnt      <= '0;
            end
          end
        end
        CALC: begin
          if (!cancel) begin
            part_rem <= step_rem;
            part_quo <= step_quo;
            cnt      <= cnt + 1'b1;
            if (last_step) begin
              quo         <= neg_q ? -step_quo : step_quo;
              rem         <= neg_r ? -step_rem : step_rem;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_stall_ctrl.sv
// tb/tb_div_stall_ctrl.sv - directed self-checking bench for div_stall_ctrl
module tb_div_stall_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         cancel;
  logic         stallreq;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int checks = 0;
  int fails  = 0;

  div_stall_ctrl #(.WIDTH(W)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .stallreq    (stallreq),
    .busy        (busy),
    .done        (done),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives start in the current cycle (T) and returns at the negedge of the done cycle.
  // lat = cycles from T to done, or -1 when the budget expires.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic hold, output int lat);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    lat       = 0;
    @(negedge clk);
    while (1) begin
      next_cycle();
      if (!hold) start = 1'b0;
      lat++;
      @(negedge clk);
      if (done) break;
      if (lat > 100) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stallreq, busy, done, div_by_zero} !== 4'b0000 || quo !== '0 || rem !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got stall=%b busy=%b done=%b dbz=%b quo=%h rem=%h, need all 0",
               stallreq, busy, done, div_by_zero, quo, rem);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_divu_basic();
    int bad_stall = 0;
    int early_done = 0;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL divu_stall_at_T: got stall=%b busy=%b, need 1 0", stallreq, busy);
    end
    for (int k = 1; k <= 32; k++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (stallreq !== 1'b1 || busy !== 1'b1) bad_stall++;
      if (done !== 1'b0) early_done++;
    end
    checks++;
    if (bad_stall != 0 || early_done != 0) begin
      fails++;
      $display("FAIL divu_calc_window: got %0d stall/busy errors and %0d early done, need 0 and 0",
               bad_stall, early_done);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || stallreq !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL divu_done_T33: got done=%b stall=%b busy=%b, need 1 0 0", done, stallreq, busy);
    end
    checks++;
    if (quo !== 32'd14 || rem !== 32'd2 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL divu_result: got quo=%0d rem=%0d dbz=%b, need 14 2 0", quo, rem, div_by_zero);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quo !== 32'd14 || rem !== 32'd2) begin
      fails++;
      $display("FAIL divu_hold: got done=%b quo=%0d rem=%0d, need 0 14 2", done, quo, rem);
    end
    next_cycle();
  endtask

  task automatic test_signed();
    int lat;
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'hFFFF_FFFD || rem !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL div_neg7_by_2: got lat=%0d quo=%h rem=%h dbz=%b, need 33 fffffffd ffffffff 0",
               lat, quo, rem, div_by_zero);
    end
    next_cycle();
    launch(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'hFFFF_FFFD || rem !== 32'd1) begin
      fails++;
      $display("FAIL div_7_by_neg2: got lat=%0d quo=%h rem=%h, need 33 fffffffd 00000001", lat, quo, rem);
    end
    next_cycle();
  endtask

  task automatic test_div_by_zero();
    start = 1'b1; signed_op = 1'b0; dividend = 32'h1234_5678; divisor = '0;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b1) begin
      fails++;
      $display("FAIL dbz_stall_at_T: got %b, need 1", stallreq);
    end
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || stallreq !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL dbz_done_T1: got done=%b stall=%b busy=%b, need 1 0 0", done, stallreq, busy);
    end
    checks++;
    if (quo !== '0 || rem !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_result: got quo=%h rem=%h dbz=%b, need 00000000 12345678 1", quo, rem, div_by_zero);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1 || rem !== 32'h1234_5678) begin
      fails++;
      $display("FAIL dbz_hold: got done=%b dbz=%b rem=%h, need 0 1 12345678", done, div_by_zero, rem);
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    int lat;
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'h8000_0000 || rem !== '0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL div_overflow: got lat=%0d quo=%h rem=%h dbz=%b, need 33 80000000 00000000 0",
               lat, quo, rem, div_by_zero);
    end
    next_cycle();
    launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'hFFFF_FFFF || rem !== '0) begin
      fails++;
      $display("FAIL divu_max_by_1: got lat=%0d quo=%h rem=%h, need 33 ffffffff 00000000", lat, quo, rem);
    end
    next_cycle();
  endtask

  task automatic test_cancel();
    int lat;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL cancel_T10_busy: got busy=%b done=%b, need 1 0", busy, done);
    end
    next_cycle();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quo !== 32'hFFFF_FFFF || rem !== '0) begin
      fails++;
      $display("FAIL cancel_T11_idle: got busy=%b done=%b quo=%h rem=%h, need 0 0 ffffffff 00000000",
               busy, done, quo, rem);
    end
    launch(1'b0, 32'd9, 32'd3, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'd3 || rem !== '0) begin
      fails++;
      $display("FAIL cancel_restart: got lat=%0d quo=%0d rem=%0d, need 33 3 0", lat, quo, rem);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_calc();
    int stray = 0;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    repeat (5) next_cycle();
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_calc_busy: got %b, need 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({stallreq, busy, done, div_by_zero} !== 4'b0000 || quo !== '0 || rem !== '0) begin
      fails++;
      $display("FAIL rst_mid_calc_outputs: got stall=%b busy=%b done=%b dbz=%b quo=%h rem=%h, need all 0",
               stallreq, busy, done, div_by_zero, quo, rem);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      fails++;
      $display("FAIL rst_no_done: got %0d cycles with done/busy, need 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1'b1; signed_op = 1'b0; dividend = 32'd20; divisor = 32'd6;
    @(negedge clk);
    next_cycle();
    dividend = 32'd50; divisor = 32'd7;
    lat = 1;
    @(negedge clk);
    while (!done && lat <= 100) begin
      next_cycle();
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 33 || quo !== 32'd3 || rem !== 32'd2 || stallreq !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d quo=%0d rem=%0d stall=%b, need 33 3 2 0", lat, quo, rem, stallreq);
    end
    next_cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b, need 0 0", busy, done);
    end
    launch(1'b0, 32'd50, 32'd7, 1'b0, lat);
    checks++;
    if (lat != 33 || quo !== 32'd7 || rem !== 32'd1) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d quo=%0d rem=%0d, need 33 7 1", lat, quo, rem);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_cancel();
    test_reset_mid_calc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
